// File: rtl/dmem_responder_if.sv
// DMEM bus between the single-cycle core (master) and the data-memory responder (slave).
// Load data returns combinationally in the same cycle as the request.
interface dmem_responder_if;
  logic [9:0]  address_DMEM;
  logic [31:0] write_data_DMEM;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] data_DMEM;

  modport master (
    output address_DMEM, write_data_DMEM, MemWrite, MemRead,
    input  data_DMEM
  );

  modport slave (
    input  address_DMEM, write_data_DMEM, MemWrite, MemRead,
    output data_DMEM
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: 1016-word RAM plus memory-mapped GPIO, cycle counter and
// compare timer in the top eight word addresses. Loads are zero-latency.
module dmem_responder #(
  parameter int GPIO_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  dmem_responder_if.slave   bus,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              timer_irq
);

  localparam logic [9:0] ADDR_MMIO_BASE = 10'h3F8;
  localparam logic [9:0] ADDR_GPIO_OUT  = 10'h3F8;
  localparam logic [9:0] ADDR_GPIO_IN   = 10'h3F9;
  localparam logic [9:0] ADDR_CYCLE     = 10'h3FA;
  localparam logic [9:0] ADDR_TMR_CMP   = 10'h3FB;
  localparam logic [9:0] ADDR_TMR_CTRL  = 10'h3FC;

  logic [31:0]       r_ram [0:1015];
  logic [GPIO_W-1:0] r_gpio_out;
  logic [GPIO_W-1:0] r_sync1;
  logic [GPIO_W-1:0] r_sync2;
  logic [31:0]       r_cycle;
  logic [31:0]       r_cmp;
  logic              r_en;
  logic              r_pending;

  logic        w_ram_sel;
  logic        w_ram_we;
  logic        w_wr_gpio;
  logic        w_wr_cycle;
  logic        w_wr_cmp;
  logic        w_wr_ctrl;
  logic        w_match;
  logic [31:0] w_rdata;

  assign w_ram_sel  = (bus.address_DMEM < ADDR_MMIO_BASE);
  assign w_ram_we   = bus.MemWrite && w_ram_sel;
  assign w_wr_gpio  = bus.MemWrite && (bus.address_DMEM == ADDR_GPIO_OUT);
  assign w_wr_cycle = bus.MemWrite && (bus.address_DMEM == ADDR_CYCLE);
  assign w_wr_cmp   = bus.MemWrite && (bus.address_DMEM == ADDR_TMR_CMP);
  assign w_wr_ctrl  = bus.MemWrite && (bus.address_DMEM == ADDR_TMR_CTRL);
  assign w_match    = r_en && (r_cycle == r_cmp);

  // RAM is deliberately outside reset so stores during RST still land and contents survive.
  always_ff @(posedge CLK) begin
    if (w_ram_we) begin
      r_ram[bus.address_DMEM] <= bus.write_data_DMEM;
    end
  end

  // MMIO registers, synchronizer and timer state; RST overrides every write and the increment.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_cycle    <= 32'h0000_0000;
      r_cmp      <= 32'hFFFF_FFFF;
      r_en       <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (w_wr_gpio) begin
        r_gpio_out <= bus.write_data_DMEM[GPIO_W-1:0];
      end
      if (w_wr_cycle) begin
        r_cycle <= bus.write_data_DMEM;
      end else begin
        r_cycle <= r_cycle + 32'd1;
      end
      if (w_wr_cmp) begin
        r_cmp <= bus.write_data_DMEM;
      end
      if (w_wr_ctrl) begin
        r_en <= bus.write_data_DMEM[0];
      end
      // A match in the same cycle as a write-1-to-clear keeps pending set.
      if (w_match) begin
        r_pending <= 1'b1;
      end else if (w_wr_ctrl && bus.write_data_DMEM[1]) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Zero-latency load mux; idle bus and reserved addresses return zero.
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (!bus.MemRead) begin
      w_rdata = 32'h0000_0000;
    end else if (w_ram_sel) begin
      w_rdata = r_ram[bus.address_DMEM];
    end else begin
      case (bus.address_DMEM)
        ADDR_GPIO_OUT: w_rdata = 32'(r_gpio_out);
        ADDR_GPIO_IN:  w_rdata = 32'(r_sync2);
        ADDR_CYCLE:    w_rdata = r_cycle;
        ADDR_TMR_CMP:  w_rdata = r_cmp;
        ADDR_TMR_CTRL: w_rdata = {30'd0, r_pending, r_en};
        default:       w_rdata = 32'h0000_0000;
      endcase
    end
  end

  assign bus.data_DMEM = w_rdata;
  assign gpio_out      = r_gpio_out;
  assign timer_irq     = r_pending & r_en;

endmodule
